// File: rtl/bomb_slot_scheduler.sv
// Shared four-slot bomb scheduler for two players. It arbitrates place-bomb presses, latches
// each bomb's tile and owner, and runs every slot through FUSE -> BLAST -> IDLE on frame ticks.
module bomb_slot_scheduler #(
    parameter int unsigned FUSE_TICKS     = 120,
    parameter int unsigned BLAST_TICKS    = 30,
    parameter int unsigned MAX_PER_PLAYER = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            tick_i,
    input  logic [1:0]      req_i,
    input  logic [1:0][5:0] tile_x_i,
    input  logic [1:0][5:0] tile_y_i,
    input  logic [3:0]      chain_hit_i,
    output logic [3:0]      bomb_on_o,
    output logic [3:0]      blast_o,
    output logic [3:0][5:0] xbomb_o,
    output logic [3:0][5:0] ybomb_o,
    output logic [3:0]      owner_o,
    output logic [1:0]      grant_o,
    output logic [1:0]      reject_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FUSE  = 2'd1,
        S_BLAST = 2'd2
    } slot_state_e;

    slot_state_e     state_q [4];
    slot_state_e     state_d [4];
    logic [7:0]      cnt_q   [4];
    logic [7:0]      cnt_d   [4];
    logic [3:0][5:0] x_q, x_d, y_q, y_d;
    logic [3:0]      owner_q, owner_d;
    logic [3:0]      bomb_on_q, blast_q;
    logic [1:0]      pending_q, pending_d;
    logic [1:0]      req_prev_q;
    logic [1:0]      grant_q, grant_d, reject_q, reject_d;
    logic            rr_q, rr_d;

    logic [3:0]      avail_s;
    logic [1:0]      clr_s;
    logic [1:0][1:0] gslot_s;
    logic            gvalid_s;
    logic [5:0]      gx_s, gy_s;
    logic            cur_s;
    logic            clash_s;
    logic [2:0]      held_s [2];

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Placement decision: serve pending players in round-robin order against the current slot state.
    always_comb begin
        avail_s  = 4'b0000;
        clr_s    = 2'b00;
        gslot_s  = '0;
        gvalid_s = 1'b0;
        gx_s     = 6'd0;
        gy_s     = 6'd0;
        cur_s    = 1'b0;
        clash_s  = 1'b0;
        grant_d  = 2'b00;
        reject_d = 2'b00;
        held_s[0] = 3'd0;
        held_s[1] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            avail_s[i] = (state_q[i] == S_IDLE);
            held_s[0]  = held_s[0] + 3'((state_q[i] != S_IDLE) && (owner_q[i] == 1'b0));
            held_s[1]  = held_s[1] + 3'((state_q[i] != S_IDLE) && (owner_q[i] == 1'b1));
        end
        for (int k = 0; k < 2; k++) begin
            cur_s   = rr_q ^ 1'(k);
            clash_s = gvalid_s && (gx_s == tile_x_i[cur_s]) && (gy_s == tile_y_i[cur_s]);
            for (int i = 0; i < 4; i++) begin
                clash_s = clash_s | ((state_q[i] != S_IDLE) && (x_q[i] == tile_x_i[cur_s])
                                     && (y_q[i] == tile_y_i[cur_s]));
            end
            if (pending_q[cur_s]) begin
                if (clash_s || (32'(held_s[cur_s]) >= MAX_PER_PLAYER)) begin
                    reject_d[cur_s] = 1'b1;
                    clr_s[cur_s]    = 1'b1;
                end else if (avail_s != 4'b0000) begin
                    gslot_s[cur_s]          = lowest_set(avail_s);
                    avail_s[gslot_s[cur_s]] = 1'b0;
                    grant_d[cur_s]          = 1'b1;
                    clr_s[cur_s]            = 1'b1;
                    gvalid_s                = 1'b1;
                    gx_s                    = tile_x_i[cur_s];
                    gy_s                    = tile_y_i[cur_s];
                end else if (gvalid_s) begin
                    // The other player took the last slot this cycle; retry next cycle.
                    clr_s[cur_s] = 1'b0;
                end else begin
                    reject_d[cur_s] = 1'b1;
                    clr_s[cur_s]    = 1'b1;
                end
            end else begin
                clr_s[cur_s] = 1'b0;
            end
        end
        rr_d      = rr_q ^ (pending_q[0] & pending_q[1]);
        pending_d = (pending_q & ~clr_s) | (req_i & ~req_prev_q);
    end

    // Per-slot lifecycle: load on grant, count fuse and blast on ticks, chain hits cut the fuse short.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            owner_d[i] = owner_q[i];
            if (grant_d[0] && (gslot_s[0] == 2'(i))) begin
                state_d[i] = S_FUSE;
                cnt_d[i]   = 8'(FUSE_TICKS);
                x_d[i]     = tile_x_i[0];
                y_d[i]     = tile_y_i[0];
                owner_d[i] = 1'b0;
            end else if (grant_d[1] && (gslot_s[1] == 2'(i))) begin
                state_d[i] = S_FUSE;
                cnt_d[i]   = 8'(FUSE_TICKS);
                x_d[i]     = tile_x_i[1];
                y_d[i]     = tile_y_i[1];
                owner_d[i] = 1'b1;
            end else begin
                case (state_q[i])
                    S_IDLE: begin
                        state_d[i] = S_IDLE;
                    end
                    S_FUSE: begin
                        if (chain_hit_i[i]) begin
                            state_d[i] = S_BLAST;
                            cnt_d[i]   = 8'(BLAST_TICKS);
                        end else if (tick_i) begin
                            if (cnt_q[i] == 8'd1) begin
                                state_d[i] = S_BLAST;
                                cnt_d[i]   = 8'(BLAST_TICKS);
                            end else begin
                                cnt_d[i] = cnt_q[i] - 8'd1;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i];
                        end
                    end
                    S_BLAST: begin
                        if (tick_i) begin
                            if (cnt_q[i] == 8'd1) begin
                                state_d[i] = S_IDLE;
                                cnt_d[i]   = 8'd0;
                                x_d[i]     = 6'd0;
                                y_d[i]     = 6'd0;
                                owner_d[i] = 1'b0;
                            end else begin
                                cnt_d[i] = cnt_q[i] - 8'd1;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i];
                        end
                    end
                    default: begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = 8'd0;
                        x_d[i]     = 6'd0;
                        y_d[i]     = 6'd0;
                        owner_d[i] = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and output registers; bomb_on/blast are registered decodes of the next slot state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= 8'd0;
            end
            x_q        <= '0;
            y_q        <= '0;
            owner_q    <= 4'b0000;
            bomb_on_q  <= 4'b0000;
            blast_q    <= 4'b0000;
            pending_q  <= 2'b00;
            req_prev_q <= 2'b00;
            grant_q    <= 2'b00;
            reject_q   <= 2'b00;
            rr_q       <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i]   <= state_d[i];
                cnt_q[i]     <= cnt_d[i];
                bomb_on_q[i] <= (state_d[i] != S_IDLE);
                blast_q[i]   <= (state_d[i] == S_BLAST);
            end
            x_q        <= x_d;
            y_q        <= y_d;
            owner_q    <= owner_d;
            pending_q  <= pending_d;
            req_prev_q <= req_i;
            grant_q    <= grant_d;
            reject_q   <= reject_d;
            rr_q       <= rr_d;
        end
    end

    assign bomb_on_o = bomb_on_q;
    assign blast_o   = blast_q;
    assign xbomb_o   = x_q;
    assign ybomb_o   = y_q;
    assign owner_o   = owner_q;
    assign grant_o   = grant_q;
    assign reject_o  = reject_q;

endmodule

// File: tb/tb_bomb_slot_scheduler.sv
// Bench for bomb_slot_scheduler: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a slot-list model of the scheduling rules.
module tb_bomb_slot_scheduler;

    localparam int FUSEP  = 4;
    localparam int BLASTP = 2;
    localparam int MAXP   = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tick = 1'b0;
    logic [1:0]      req = 2'b00;
    logic [1:0][5:0] tx = '0;
    logic [1:0][5:0] ty = '0;
    logic [3:0]      chain = 4'b0000;
    logic [3:0]      bomb_on, blast, owner;
    logic [3:0][5:0] xbomb, ybomb;
    logic [1:0]      grant, reject;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    bit         m_busy [4];
    bit         m_blast[4];
    int         m_rem  [4];
    int         m_x    [4];
    int         m_y    [4];
    int         m_own  [4];
    bit         m_pend [2];
    bit         m_prev [2];
    int         m_rr;
    logic [1:0] e_grant, e_reject;

    bomb_slot_scheduler #(
        .FUSE_TICKS    (FUSEP),
        .BLAST_TICKS   (BLASTP),
        .MAX_PER_PLAYER(MAXP)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tick_i     (tick),
        .req_i      (req),
        .tile_x_i   (tx),
        .tile_y_i   (ty),
        .chain_hit_i(chain),
        .bomb_on_o  (bomb_on),
        .blast_o    (blast),
        .xbomb_o    (xbomb),
        .ybomb_o    (ybomb),
        .owner_o    (owner),
        .grant_o    (grant),
        .reject_o   (reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_busy[s] = 0; m_blast[s] = 0; m_rem[s] = 0; m_x[s] = 0; m_y[s] = 0; m_own[s] = 0;
        end
        m_pend[0] = 0; m_pend[1] = 0; m_prev[0] = 0; m_prev[1] = 0;
        m_rr = 0; e_grant = 2'b00; e_reject = 2'b00;
    endtask

    task automatic model_step();
        int gslot[2];
        bit clr[2];
        bit taken[4];
        bit any_g, clash, both;
        int gx, gy, p, own, fs;
        gslot[0] = -1; gslot[1] = -1; clr[0] = 0; clr[1] = 0;
        for (int s = 0; s < 4; s++) taken[s] = 0;
        any_g = 0; gx = -1; gy = -1;
        e_grant = 2'b00; e_reject = 2'b00;
        both = m_pend[0] && m_pend[1];
        for (int k = 0; k < 2; k++) begin
            p = m_rr ^ k;
            if (m_pend[p]) begin
                own = 0;
                clash = any_g && gx == int'(tx[p]) && gy == int'(ty[p]);
                for (int s = 0; s < 4; s++) begin
                    if (m_busy[s]) begin
                        if (m_own[s] == p) own++;
                        if (m_x[s] == int'(tx[p]) && m_y[s] == int'(ty[p])) clash = 1;
                    end
                end
                fs = -1;
                for (int s = 3; s >= 0; s--) if (!m_busy[s] && !taken[s]) fs = s;
                if (clash || own >= MAXP) begin
                    e_reject[p] = 1'b1; clr[p] = 1;
                end else if (fs >= 0) begin
                    taken[fs] = 1; any_g = 1; gx = int'(tx[p]); gy = int'(ty[p]);
                    gslot[p] = fs; e_grant[p] = 1'b1; clr[p] = 1;
                end else if (!any_g) begin
                    e_reject[p] = 1'b1; clr[p] = 1;
                end
            end
        end
        if (both) m_rr = 1 - m_rr;
        for (int s = 0; s < 4; s++) begin
            if (m_busy[s]) begin
                if (!m_blast[s]) begin
                    if (chain[s]) begin
                        m_blast[s] = 1; m_rem[s] = BLASTP;
                    end else if (tick) begin
                        m_rem[s]--;
                        if (m_rem[s] == 0) begin m_blast[s] = 1; m_rem[s] = BLASTP; end
                    end
                end else if (tick) begin
                    m_rem[s]--;
                    if (m_rem[s] == 0) begin
                        m_busy[s] = 0; m_blast[s] = 0; m_x[s] = 0; m_y[s] = 0; m_own[s] = 0;
                    end
                end
            end
        end
        for (int q = 0; q < 2; q++) begin
            if (gslot[q] >= 0) begin
                m_busy[gslot[q]] = 1; m_blast[gslot[q]] = 0; m_rem[gslot[q]] = FUSEP;
                m_x[gslot[q]] = int'(tx[q]); m_y[gslot[q]] = int'(ty[q]); m_own[gslot[q]] = q;
            end
        end
        for (int q = 0; q < 2; q++) begin
            m_pend[q] = (m_pend[q] && !clr[q]) || (req[q] && !m_prev[q]);
            m_prev[q] = req[q];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [3:0] eo, eb, ew;
        logic [3:0][5:0] ex, ey;
        if (chk_en) begin
            for (int s = 0; s < 4; s++) begin
                eo[s] = m_busy[s]; eb[s] = m_blast[s]; ew[s] = 1'(m_own[s]);
                ex[s] = 6'(m_x[s]); ey[s] = 6'(m_y[s]);
            end
            check("bomb_on", int'(bomb_on), int'(eo));
            check("blast", int'(blast), int'(eb));
            check("owner", int'(owner), int'(ew));
            check("xbomb", int'(xbomb), int'(ex));
            check("ybomb", int'(ybomb), int'(ey));
            check("grant", int'(grant), int'(e_grant));
            check("reject", int'(reject), int'(e_reject));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic press(input int p, input int x, input int y);
        tx[p] = 6'(x); ty[p] = 6'(y); req[p] = 1'b1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        step();
        chk_en = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        check("reset_bomb_on", int'(bomb_on), 0);
        check("reset_grant", int'(grant), 0);

        // Single placement and full fuse/blast lifecycle.
        press(0, 3, 2);
        step();
        check("t1_not_yet", int'(bomb_on), 0);
        step();
        check("t1_grant", int'(grant), 1);
        check("t1_on", int'(bomb_on), 1);
        check("t1_x", int'(xbomb[0]), 3);
        check("t1_y", int'(ybomb[0]), 2);
        req = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
            if (i == 3) check("t1_fuse3", int'(blast), 0);
            if (i == 4) check("t1_blast4", int'(blast), 1);
            if (i == 6) begin
                check("t1_idle6", int'(bomb_on), 0);
                check("t1_x_clr", int'(xbomb[0]), 0);
            end
            repeat (9) step();
        end

        // Simultaneous presses on distinct tiles.
        press(0, 1, 1); press(1, 5, 5);
        step(); step();
        check("t2_grant", int'(grant), 3);
        check("t2_on", int'(bomb_on), 3);
        check("t2_owner", int'(owner), 2);
        check("t2_x1", int'(xbomb[1]), 5);
        req = 2'b00;
        step();
        check("t2_pulse", int'(grant), 0);

        // Last free slot contention: round-robin winner first, loser retried then rejected.
        press(0, 2, 2); step(); step(); req = 2'b00; step();
        press(0, 3, 3); press(1, 4, 4);
        step(); step();
        check("t3_grant", int'(grant), 2);
        check("t3_noreject", int'(reject), 0);
        check("t3_owner3", int'(owner[3]), 1);
        step();
        check("t3_reject", int'(reject), 1);
        check("t3_nogrant", int'(grant), 0);
        req = 2'b00; step();
        tick_n(6);
        check("t3_cleared", int'(bomb_on), 0);

        // Per-player limit, then a held key must stay silent.
        for (int b = 0; b < 3; b++) begin
            press(0, 10 + b, 1); step(); step(); req = 2'b00; step();
        end
        press(0, 13, 1); step(); step();
        check("t4_reject", int'(reject), 1);
        check("t4_nogrant", int'(grant), 0);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            pulses += int'(grant != 2'b00) + int'(reject != 2'b00);
        end
        check("t4_held", pulses, 0);
        req = 2'b00; step();

        // Chain hit forces blast; pressing an occupied tile is refused.
        chain = 4'b0010; step(); chain = 4'b0000;
        check("t5_blast", int'(blast), 2);
        press(1, 11, 1); step(); step();
        check("t5_reject", int'(reject), 2);
        check("t5_nogrant", int'(grant), 0);
        req = 2'b00; step();

        // Asynchronous reset with both requests pending and a slot blasting.
        press(0, 20, 20); press(1, 21, 21); step();
        rst_n = 1'b0; #1;
        check("t6_async_on", int'(bomb_on), 0);
        check("t6_async_blast", int'(blast), 0);
        check("t6_async_x", int'(xbomb), 0);
        req = 2'b00;
        step(); step();
        rst_n = 1'b1; #1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(grant != 2'b00);
        end
        check("t6_no_grant", pulses, 0);
        press(0, 20, 20); step(); step();
        check("t6_fresh", int'(grant), 1);
        req = 2'b00; step();

        // Randomized traffic on a small tile grid to provoke clashes and contention.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) == 0) req[p] = ~req[p];
                if ($urandom_range(0, 3) == 0) begin
                    tx[p] = 6'($urandom_range(0, 3)); ty[p] = 6'($urandom_range(0, 2));
                end
            end
            tick = ($urandom_range(0, 2) == 0);
            for (int s = 0; s < 4; s++) chain[s] = ($urandom_range(0, 11) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1;
        tick = 1'b0; chain = 4'b0000; req = 2'b00;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
